// File: rtl/fenrir_axi_lite_regs_if.sv
`default_nettype none
// ============================================================================
// Module      : fenrir_axi_lite_regs_if
// Description : AXI4-Lite bus bundle for the S00_AXI port of the fenrir_axi
//               IP. Carries all five AXI4-Lite channels (AW, W, B, AR, R).
// Modports    : master - drives addresses, data, valids and response readies
//               slave  - drives channel readies, responses and read data
// Revision    : 1.0 - initial release
// ============================================================================
interface fenrir_axi_lite_regs_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/fenrir_axi_lite_regs.sv
`default_nettype none
// ============================================================================
// Module      : fenrir_axi_lite_regs
// Description : AXI4-Lite slave register bank with four 32-bit read/write
//               registers at 0x0/0x4/0x8/0xC and a one-cycle write strobe
//               per register toward the Fenrir core.
// Ports       : S_AXI_ACLK   - clock, rising edge
//               S_AXI_ARESET - asynchronous active-high reset
//               s_axi        - AXI4-Lite slave bus (AW, W, B, AR, R)
//               reg_out      - {reg3, reg2, reg1, reg0}, registered
//               reg_wr_pulse - bit i high for one cycle after reg i commits
// Revision    : 1.0 - initial release
// ============================================================================
module fenrir_axi_lite_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  wire logic                              S_AXI_ACLK,
    input  wire logic                              S_AXI_ARESET,
    fenrir_axi_lite_regs_if.slave                  s_axi,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0]        reg_out,
    output logic [3:0]                             reg_wr_pulse
);
    localparam int c_NUM_REGS   = 4;
    localparam int c_STRB_WIDTH = C_S_AXI_DATA_WIDTH / 8;

    // Write-side single-entry buffers
    logic                          r_aw_held;
    logic [1:0]                    r_aw_sel;
    logic                          r_w_held;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_w_data;
    logic [c_STRB_WIDTH-1:0]       r_w_strb;
    logic                          r_bvalid;
    logic [3:0]                    r_wr_pulse;

    // Read-side state
    logic                          r_rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

    logic [C_S_AXI_DATA_WIDTH-1:0] r_regs [c_NUM_REGS];

    logic                          w_awready;
    logic                          w_wready;
    logic                          w_arready;
    logic                          w_aw_hs;
    logic                          w_w_hs;
    logic                          w_ar_hs;
    logic                          w_commit;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_merged;

    // Holding BVALID blocks both write channels, which keeps exactly one
    // write outstanding and stops a new address overwriting r_aw_sel
    // before its response has been taken.
    assign w_awready = !r_aw_held && !r_bvalid;
    assign w_wready  = !r_w_held  && !r_bvalid;
    assign w_arready = !r_rvalid;

    assign w_aw_hs  = s_axi.awvalid && w_awready;
    assign w_w_hs   = s_axi.wvalid  && w_wready;
    assign w_ar_hs  = s_axi.arvalid && w_arready;
    assign w_commit = r_aw_held && r_w_held && !r_bvalid;

    // Byte-wise merge of buffered write data into the addressed register
    for (genvar k = 0; k < c_STRB_WIDTH; k++) begin : g_byte_merge
        assign w_merged[8*k +: 8] = r_w_strb[k] ? r_w_data[8*k +: 8]
                                                : r_regs[r_aw_sel][8*k +: 8];
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_aw_held  <= 1'b0;
            r_aw_sel   <= 2'd0;
            r_w_held   <= 1'b0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_bvalid   <= 1'b0;
            r_wr_pulse <= 4'b0000;
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_wr_pulse <= w_commit ? (4'b0001 << r_aw_sel) : 4'b0000;

            if (w_commit) begin
                r_regs[r_aw_sel] <= w_merged;
                r_aw_held        <= 1'b0;
                r_w_held         <= 1'b0;
                r_bvalid         <= 1'b1;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_aw_sel  <= s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_w_data <= s_axi.wdata;
                    r_w_strb <= s_axi.wstrb;
                end
                if (r_bvalid && s_axi.bready) begin
                    r_bvalid <= 1'b0;
                end
            end
        end
    end

    // A read sampling the register on a commit edge sees the old contents,
    // since the register update is non-blocking on the same edge.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= r_regs[s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2]];
            end else if (r_rvalid && s_axi.rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < c_NUM_REGS; i++) begin : g_reg_out
        assign reg_out[i*C_S_AXI_DATA_WIDTH +: C_S_AXI_DATA_WIDTH] = r_regs[i];
    end

    assign reg_wr_pulse  = r_wr_pulse;
    assign s_axi.awready = w_awready;
    assign s_axi.wready  = w_wready;
    assign s_axi.bresp   = 2'b00;
    assign s_axi.bvalid  = r_bvalid;
    assign s_axi.arready = w_arready;
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = 2'b00;
    assign s_axi.rvalid  = r_rvalid;

    // Protection bits and byte-offset address bits carry no meaning here.
    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, s_axi.awprot, s_axi.arprot,
                             s_axi.awaddr[1:0], s_axi.araddr[1:0]};
endmodule
`default_nettype wire

// File: tb/tb_fenrir_axi_lite_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_fenrir_axi_lite_regs
// Description : Self-checking bench for fenrir_axi_lite_regs. Directed
//               scenarios plus randomized traffic checked against an
//               array-based register model.
// Ports       : none (top-level bench)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fenrir_axi_lite_regs;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] reg_out;
    logic [3:0]   reg_wr_pulse;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [4];
    int          pulse_cnt [4];

    always #5 clk = ~clk;

    fenrir_axi_lite_regs_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

    fenrir_axi_lite_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .s_axi        (bus),
        .reg_out      (reg_out),
        .reg_wr_pulse (reg_wr_pulse)
    );

    always @(negedge clk) begin
        for (int p = 0; p < 4; p++) begin
            if (reg_wr_pulse[p]) pulse_cnt[p]++;
        end
    end

    function automatic void model_write(input logic [3:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb);
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) model[addr[3:2]][8*k +: 8] = data[8*k +: 8];
        end
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 4; k++) model[k] = 32'h0;
    endfunction

    // Drives AW and W together until both handshake. Starts/ends at negedge.
    task automatic send_aw_w(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output bit timeout);
        bit aw_done, w_done, aw_hs, w_hs;
        int n;
        aw_done = 0; w_done = 0; n = 0; timeout = 0;
        bus.awaddr  = addr;
        bus.awprot  = 3'($urandom);
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        while (!(aw_done && w_done) && !timeout) begin
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            @(negedge clk);
            if (aw_hs) begin bus.awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin bus.wvalid  = 1'b0; w_done  = 1; end
            n++;
            if (n > 50) timeout = 1;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp,
                            output bit timeout);
        int n;
        resp = 2'bxx;
        send_aw_w(addr, data, strb, timeout);
        n = 0;
        while (!bus.bvalid && !timeout) begin
            @(negedge clk);
            n++;
            if (n > 50) timeout = 1;
        end
        if (!timeout) begin
            resp = bus.bresp;
            @(negedge clk);
        end
    endtask

    task automatic do_read(input logic [3:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output bit timeout);
        bit done, hs;
        int n;
        done = 0; n = 0; timeout = 0; data = 'x; resp = 2'bxx;
        bus.araddr  = addr;
        bus.arprot  = 3'($urandom);
        bus.arvalid = 1'b1;
        while (!done && !timeout) begin
            hs = bus.arvalid && bus.arready;
            @(negedge clk);
            if (hs) begin bus.arvalid = 1'b0; done = 1; end
            n++;
            if (n > 50) timeout = 1;
        end
        bus.arvalid = 1'b0;
        n = 0;
        while (!bus.rvalid && !timeout) begin
            @(negedge clk);
            n++;
            if (n > 50) timeout = 1;
        end
        if (!timeout) begin
            data = bus.rdata;
            resp = bus.rresp;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (bus.bvalid !== 1'b0) begin bad++; $display("FAIL reset_bvalid got=%0h exp=0", bus.bvalid); end
        total++; if (bus.rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%0h exp=0", bus.rvalid); end
        total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata); end
        total++; if (reg_out !== 128'h0) begin bad++; $display("FAIL reset_reg_out got=%h exp=0", reg_out); end
        total++; if (reg_wr_pulse !== 4'h0) begin bad++; $display("FAIL reset_pulse got=%h exp=0", reg_wr_pulse); end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
            bad++; $display("FAIL reset_readies got=%b exp=111", {bus.awready, bus.wready, bus.arready});
        end
        model_clear();
    endtask

    task automatic test_seq_write_read();
        logic [1:0]  resp;
        logic [31:0] d;
        bit          to;
        for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;
        for (int i = 0; i < 4; i++) begin
            do_write(4'(i * 4), 32'(i + 1), 4'hF, resp, to);
            model_write(4'(i * 4), 32'(i + 1), 4'hF);
            total++; if (to || resp !== 2'b00) begin bad++; $display("FAIL seq_bresp reg=%0d got=%b to=%0d exp=00", i, resp, to); end
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            total++; if (pulse_cnt[i] != 1) begin bad++; $display("FAIL seq_pulse bit=%0d got=%0d exp=1", i, pulse_cnt[i]); end
        end
        total++;
        if (reg_out !== 128'h00000004_00000003_00000002_00000001) begin
            bad++; $display("FAIL seq_reg_out got=%h exp=00000004000000030000000200000001", reg_out);
        end
        for (int i = 0; i < 4; i++) begin
            do_read(4'(i * 4), d, resp, to);
            total++;
            if (to || d !== 32'(i + 1) || resp !== 2'b00) begin
                bad++; $display("FAIL seq_read reg=%0d got=%h resp=%b to=%0d exp=%h", i, d, resp, to, i + 1);
            end
        end
    endtask

    task automatic test_skew();
        // W leads AW by three cycles
        bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        total++; if (bus.wready !== 1'b1) begin bad++; $display("FAIL skew_w_ready got=%0h exp=1", bus.wready); end
        @(negedge clk);
        bus.wvalid = 1'b0;
        repeat (3) begin
            total++;
            if (bus.awready !== 1'b1 || bus.wready !== 1'b0) begin
                bad++; $display("FAIL skew_w_first_readies got aw=%0h w=%0h exp aw=1 w=0", bus.awready, bus.wready);
            end
            @(negedge clk);
        end
        bus.awaddr = 4'h8; bus.awprot = 3'($urandom); bus.awvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        total++;
        if (bus.bvalid !== 1'b0 || reg_out[95:64] !== model[2]) begin
            bad++; $display("FAIL skew_early_commit got bvalid=%0h reg2=%h exp bvalid=0 reg2=%h", bus.bvalid, reg_out[95:64], model[2]);
        end
        @(negedge clk);
        total++;
        if (bus.bvalid !== 1'b1 || reg_out[95:64] !== 32'hDEADBEEF || bus.bresp !== 2'b00) begin
            bad++; $display("FAIL skew_commit got bvalid=%0h reg2=%h exp bvalid=1 reg2=deadbeef", bus.bvalid, reg_out[95:64]);
        end
        model[2] = 32'hDEADBEEF;
        @(negedge clk);
        total++; if (bus.bvalid !== 1'b0) begin bad++; $display("FAIL skew_b_done got=%0h exp=0", bus.bvalid); end

        // AW leads W by three cycles; unaligned address aliases to reg2
        bus.awaddr = 4'hB; bus.awprot = 3'($urandom); bus.awvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        repeat (3) begin
            total++;
            if (bus.awready !== 1'b0 || bus.wready !== 1'b1) begin
                bad++; $display("FAIL skew_aw_first_readies got aw=%0h w=%0h exp aw=0 w=1", bus.awready, bus.wready);
            end
            @(negedge clk);
        end
        bus.wdata = 32'h0BADF00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.wvalid = 1'b0;
        @(negedge clk);
        total++;
        if (bus.bvalid !== 1'b1 || reg_out[95:64] !== 32'h0BADF00D) begin
            bad++; $display("FAIL skew_rev_commit got bvalid=%0h reg2=%h exp bvalid=1 reg2=0badf00d", bus.bvalid, reg_out[95:64]);
        end
        model[2] = 32'h0BADF00D;
        @(negedge clk);
    endtask

    task automatic test_strobes();
        logic [1:0]  resp;
        logic [31:0] d;
        bit          to;
        do_write(4'h4, 32'hFFFFFFFF, 4'hF, resp, to);
        do_write(4'h4, 32'h12345678, 4'b0101, resp, to);
        model_write(4'h4, 32'hFFFFFFFF, 4'hF);
        model_write(4'h4, 32'h12345678, 4'b0101);
        do_read(4'h4, d, resp, to);
        total++; if (to || d !== 32'hFF34FF78) begin bad++; $display("FAIL strobe_read got=%h to=%0d exp=ff34ff78", d, to); end

        // Zero strobe: OKAY response, pulse, register untouched
        for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;
        do_write(4'h0, 32'hCAFEF00D, 4'h0, resp, to);
        @(negedge clk);
        total++; if (to || resp !== 2'b00) begin bad++; $display("FAIL strobe_zero_bresp got=%b to=%0d exp=00", resp, to); end
        total++; if (pulse_cnt[0] != 1) begin bad++; $display("FAIL strobe_zero_pulse got=%0d exp=1", pulse_cnt[0]); end
        total++; if (reg_out[31:0] !== model[0]) begin bad++; $display("FAIL strobe_zero_reg got=%h exp=%h", reg_out[31:0], model[0]); end
    endtask

    task automatic test_backpressure();
        logic [1:0]  resp;
        logic [31:0] d;
        bit          to;
        int          n;
        bus.bready = 1'b0;
        send_aw_w(4'h4, 32'h55AA33CC, 4'hF, to);
        model_write(4'h4, 32'h55AA33CC, 4'hF);
        n = 0;
        while (!bus.bvalid && n < 20) begin @(negedge clk); n++; end
        total++; if (to || bus.bvalid !== 1'b1) begin bad++; $display("FAIL bp_bvalid_timeout got=%0h exp=1", bus.bvalid); end
        // Offer a second write while the response is stalled
        bus.awaddr = 4'h8; bus.wdata = 32'h77777777; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        repeat (5) begin
            total++;
            if (bus.bvalid !== 1'b1 || bus.awready !== 1'b0 || bus.wready !== 1'b0 || reg_out[95:64] !== model[2]) begin
                bad++; $display("FAIL bp_b_hold got bvalid=%0h aw=%0h w=%0h reg2=%h exp 1/0/0/%h",
                                bus.bvalid, bus.awready, bus.wready, reg_out[95:64], model[2]);
            end
            @(negedge clk);
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        @(negedge clk);
        total++; if (bus.bvalid !== 1'b0) begin bad++; $display("FAIL bp_b_release got=%0h exp=0", bus.bvalid); end
        do_write(4'h8, 32'h77777777, 4'hF, resp, to);
        model_write(4'h8, 32'h77777777, 4'hF);
        total++; if (to || reg_out[95:64] !== 32'h77777777) begin bad++; $display("FAIL bp_second_write got=%h to=%0d exp=77777777", reg_out[95:64], to); end

        // Read-side stall
        bus.rready = 1'b0;
        bus.araddr = 4'h4; bus.arvalid = 1'b1;
        @(negedge clk);
        bus.araddr = 4'h8;   // would change RDATA if wrongly accepted
        repeat (5) begin
            total++;
            if (bus.rvalid !== 1'b1 || bus.arready !== 1'b0 || bus.rdata !== model[1]) begin
                bad++; $display("FAIL bp_r_hold got rvalid=%0h ar=%0h rdata=%h exp 1/0/%h",
                                bus.rvalid, bus.arready, bus.rdata, model[1]);
            end
            @(negedge clk);
        end
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        @(negedge clk);
        total++; if (bus.rvalid !== 1'b0 || bus.rdata !== model[1]) begin bad++; $display("FAIL bp_r_release got rvalid=%0h rdata=%h exp 0/%h", bus.rvalid, bus.rdata, model[1]); end
        do_read(4'h8, d, resp, to);
        total++; if (to || d !== model[2]) begin bad++; $display("FAIL bp_read_after got=%h exp=%h", d, model[2]); end
    endtask

    task automatic test_collision();
        logic [1:0]  resp;
        logic [31:0] d;
        bit          to;
        do_write(4'hC, 32'h0000000A, 4'hF, resp, to);
        bus.awaddr = 4'hC; bus.wdata = 32'h0000000B; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.araddr = 4'hC; bus.arvalid = 1'b1;
        @(negedge clk);
        bus.arvalid = 1'b0;
        total++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h0000000A || bus.bvalid !== 1'b1) begin
            bad++; $display("FAIL collision_read got rvalid=%0h rdata=%h bvalid=%0h exp 1/0000000a/1", bus.rvalid, bus.rdata, bus.bvalid);
        end
        model[3] = 32'h0000000B;
        @(negedge clk);
        do_read(4'hC, d, resp, to);
        total++; if (to || d !== 32'h0000000B) begin bad++; $display("FAIL collision_reread got=%h exp=0000000b", d); end
    endtask

    task automatic test_reset_mid();
        logic [1:0]  resp;
        logic [31:0] d;
        bit          to;
        bit          saw_b;
        bus.awaddr = 4'h4; bus.awvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        saw_b = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.bvalid) saw_b = 1;
        end
        total++; if (saw_b) begin bad++; $display("FAIL rstmid_bvalid got=1 exp=0"); end
        for (int i = 0; i < 4; i++) begin
            do_read(4'(i * 4), d, resp, to);
            total++; if (to || d !== 32'h0) begin bad++; $display("FAIL rstmid_read reg=%0d got=%h exp=0", i, d); end
        end
        do_write(4'h4, 32'h13579BDF, 4'hF, resp, to);
        model_write(4'h4, 32'h13579BDF, 4'hF);
        do_read(4'h4, d, resp, to);
        total++; if (to || d !== 32'h13579BDF) begin bad++; $display("FAIL rstmid_write got=%h exp=13579bdf", d); end
    endtask

    task automatic test_random();
        logic [1:0]  resp;
        logic [31:0] d, data;
        logic [3:0]  addr, strb;
        bit          to;
        for (int i = 0; i < 80; i++) begin
            addr = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom;
                strb = 4'($urandom_range(0, 15));
                do_write(addr, data, strb, resp, to);
                model_write(addr, data, strb);
                total++; if (to || resp !== 2'b00) begin bad++; $display("FAIL rand_write op=%0d got resp=%b to=%0d exp=00", i, resp, to); end
            end else begin
                do_read(addr, d, resp, to);
                total++;
                if (to || d !== model[addr[3:2]] || resp !== 2'b00) begin
                    bad++; $display("FAIL rand_read op=%0d addr=%h got=%h exp=%h", i, addr, d, model[addr[3:2]]);
                end
            end
        end
        total++;
        if (reg_out !== {model[3], model[2], model[1], model[0]}) begin
            bad++; $display("FAIL rand_reg_out got=%h exp=%h", reg_out, {model[3], model[2], model[1], model[0]});
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
        for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_seq_write_read();
        test_skew();
        test_strobes();
        test_backpressure();
        test_collision();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/fenrir_axi_lite_regs.md
Name: fenrir_axi_lite_regs

Overview:
- AXI4-Lite slave register bank that terminates the S00_AXI port of the fenrir_axi IP.
- Exposes four 32-bit read/write registers (0x0, 0x4, 0x8, 0xC) to the Fenrir core, with a one-cycle per-register write pulse.
- Sits directly downstream of the AXI master (PS or VIP master agent) and upstream of the core's control logic.
- Any master doing four sequential writes followed by four readbacks must read back exactly what it wrote.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register, bits [1:0] are ignored.

Ports:
- S_AXI_ACLK  in  1  clock; all logic on its rising edge.
- S_AXI_ARESET  in  1  reset, asynchronous, active-high.
- S_AXI_AWADDR  in  4  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR  in  4  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00 (OKAY).
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.
- reg_out  out  128  {reg3, reg2, reg1, reg0}; registered, drives the core.
- reg_wr_pulse  out  4  one-cycle strobe, bit i high in the cycle after reg i is committed.

Behaviour:
- Reset (async assert, released synchronously to the design): the following are cleared to 0:
  - all registers;
  - BVALID, RVALID, RDATA;
  - reg_wr_pulse;
  - the internal aw_held and w_held flags.
- Reset asserted mid-transaction aborts the transaction with no response; a partially buffered write is discarded.
- Write path: AW and W channels are accepted independently into single-entry buffers.
  - AWREADY = !aw_held && !BVALID.
  - WREADY = !w_held && !BVALID.
  - AW handshake latches AWADDR[3:2] and sets aw_held; W handshake latches WDATA/WSTRB and sets w_held.
  - On the first edge where aw_held && w_held && !BVALID (commit edge):
    - reg[addr] byte k is updated only where WSTRB[k] = 1;
    - aw_held and w_held are cleared;
    - BVALID <= 1;
    - reg_wr_pulse[addr] <= 1 for one cycle.
  - AW and W may arrive in either order, in the same cycle, or any number of cycles apart.
  - Latency: with both handshakes on edge E, the commit is on E+1; BVALID and the new reg_out are visible after E+1.
  - BVALID holds until BVALID && BREADY; no new AW or W is accepted while BVALID is high (one outstanding write).
  - WSTRB = 0 still completes with OKAY, leaves the register unchanged, and still pulses reg_wr_pulse.
- Read path:
  - ARREADY = !RVALID.
  - On an AR handshake edge: RDATA <= reg[ARADDR[3:2]] and RVALID <= 1. Read latency is 1 cycle.
  - RVALID and RDATA hold stable until the RVALID && RREADY edge, which clears RVALID. RDATA keeps its last value.
  - One outstanding read.
- Read and write are fully independent and may handshake on the same edge.
- If an AR handshake coincides with a commit to the same register, RDATA returns the pre-commit value.
- No SLVERR or DECERR is ever returned: every address maps, and unaligned addresses alias to the word.
- AWPROT and ARPROT have no effect.

Test Plan:
- Sequential writes then readback:
  - Write 0x1, 0x2, 0x3, 0x4 to 0x0/0x4/0x8/0xC, then read all four.
  - Required: RDATA = 0x1..0x4, all BRESP/RRESP OKAY, reg_wr_pulse bits 0..3 each high exactly once, reg_out = 0x00000004_00000003_00000002_00000001.
- Channel skew:
  - W (0xDEADBEEF) arrives 3 cycles before AW (0x8); AWREADY must stay high and WREADY low until the AW handshake.
  - Required: reg2 = 0xDEADBEEF one cycle after the AW handshake, then BVALID; the reverse order gives the same result.
- Byte strobes:
  - reg1 = 0xFFFFFFFF, then write 0x12345678 with WSTRB = 4'b0101.
  - Required: readback 0xFF34FF78.
- Backpressure:
  - Hold BREADY = 0 for 5 cycles after a write. Required: BVALID stays high, AWREADY and WREADY stay low, and a second write is not accepted until the B handshake.
  - Hold RREADY = 0 for 5 cycles. Required: RDATA stays stable and ARREADY stays low.
- Collision:
  - reg3 = 0xA; AR to 0xC on the same edge as a commit of 0xB to reg3.
  - Required: RDATA = 0xA; a subsequent read returns 0xB.
- Reset mid-operation:
  - Assert S_AXI_ARESET after an AW handshake but before W.
  - Required: BVALID never asserts, all registers read 0, and the next full write completes normally.
